// File: rtl/phv_assembler_if.sv
// phv_assembler_if: handshake bundle between the action ALUs, the PHV assembler and the
// next stage.
//   master : drives the ALU bundle (alu_out_valid, alu_out_4B, phv_remain_data) and the
//            downstream ready_in; observes ready_out, phv_out and phv_out_valid.
//   slave  : the assembler side of the same signals.
interface phv_assembler_if #(
  parameter int unsigned PHV_LEN  = 4*8*64+256,
  parameter int unsigned width_4B = 32,
  parameter int unsigned NUM_CONT = 64
);
  logic                         alu_out_valid;
  logic [width_4B*NUM_CONT-1:0] alu_out_4B;
  logic [255:0]                 phv_remain_data;
  logic                         ready_out;
  logic [PHV_LEN-1:0]           phv_out;
  logic                         phv_out_valid;
  logic                         ready_in;

  modport master (
    output alu_out_valid, alu_out_4B, phv_remain_data, ready_in,
    input  ready_out, phv_out, phv_out_valid
  );

  modport slave (
    input  alu_out_valid, alu_out_4B, phv_remain_data, ready_in,
    output ready_out, phv_out, phv_out_valid
  );
endinterface

// File: rtl/phv_assembler.sv
// phv_assembler: rebuilds the full PHV from the 64 per-container ALU results plus the untouched
// 256-bit metadata tail, and buffers it in a small show-ahead FIFO so that ALU timing is
// decoupled from downstream backpressure.
// Ports:
//   clk, rst_n    : stage clock, asynchronous active-low reset
//   bus (slave)   : ALU bundle in (valid/ready_out), reassembled PHV out (valid/ready_in)
//   pkt_in_cnt    : bundles accepted (wrapping)
//   pkt_out_cnt   : PHVs delivered (wrapping)
//   overflow_err  : sticky, set when a bundle arrives while ready_out is low
module phv_assembler #(
  parameter int          STAGE_ID   = 0,
  parameter int unsigned PHV_LEN    = 4*8*64+256,
  parameter int unsigned width_4B   = 32,
  parameter int unsigned NUM_CONT   = 64,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  phv_assembler_if.slave   bus,
  output logic [CNT_W-1:0] pkt_in_cnt,
  output logic [CNT_W-1:0] pkt_out_cnt,
  output logic             overflow_err
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  if (PHV_LEN != NUM_CONT * width_4B + 256) begin : g_len_err
    $error("phv_assembler stage %0d: PHV_LEN inconsistent with NUM_CONT*width_4B+256",
           STAGE_ID);
  end
  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 8) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0))
  begin : g_depth_err
    $error("phv_assembler stage %0d: FIFO_DEPTH must be a power of two in 2..8", STAGE_ID);
  end

  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    count_q, count_d;
  logic [CNT_W-1:0]   pkt_in_cnt_q, pkt_in_cnt_d;
  logic [CNT_W-1:0]   pkt_out_cnt_q, pkt_out_cnt_d;
  logic               overflow_q, overflow_d;
  logic [PHV_LEN-1:0] mem_q [FIFO_DEPTH];
  logic [PHV_LEN-1:0] packed_phv;
  logic               not_empty, not_full, push, pop;

  // Container i lands at phv[PHV_LEN-1-width_4B*(NUM_CONT-1-i) -: width_4B], which is a plain
  // concatenation with the metadata tail in the low 256 bits.
  assign packed_phv = {bus.alu_out_4B, bus.phv_remain_data};

  // Both flags come from the registered count only: a pop while full does not open ready_out
  // in the same cycle.
  assign not_empty = (count_q != '0);
  assign not_full  = (count_q != CntW'(FIFO_DEPTH));
  assign push      = bus.alu_out_valid && not_full;
  assign pop       = not_empty && bus.ready_in;

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    pkt_in_cnt_d  = pkt_in_cnt_q;
    pkt_out_cnt_d = pkt_out_cnt_q;
    overflow_d    = overflow_q | (bus.alu_out_valid & ~not_full);

    if (push) begin
      wr_ptr_d     = wr_ptr_q + PtrW'(1);
      pkt_in_cnt_d = pkt_in_cnt_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d      = rd_ptr_q + PtrW'(1);
      pkt_out_cnt_d = pkt_out_cnt_q + CNT_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pkt_in_cnt_q  <= '0;
      pkt_out_cnt_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pkt_in_cnt_q  <= pkt_in_cnt_d;
      pkt_out_cnt_q <= pkt_out_cnt_d;
      overflow_q    <= overflow_d;
    end
  end

  // Entry storage is deliberately left out of reset; the output mux below hides stale entries.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= packed_phv;
    end
  end

  assign bus.ready_out     = not_full;
  assign bus.phv_out_valid = not_empty;
  // Zero when empty so that reset (and any drained state) presents phv_out = 0.
  assign bus.phv_out       = not_empty ? mem_q[rd_ptr_q] : '0;

  assign pkt_in_cnt   = pkt_in_cnt_q;
  assign pkt_out_cnt  = pkt_out_cnt_q;
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_phv_assembler.sv
// Directed + randomised bench for phv_assembler. A queue scoreboard tracks the expected FIFO
// contents and counters cycle by cycle; directed sections add hand-computed spot checks.
module tb_phv_assembler;
  localparam int unsigned PhvLen = 2304;
  localparam int unsigned Depth  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  phv_assembler_if bus_if ();
  logic [31:0] pkt_in_cnt, pkt_out_cnt;
  logic        overflow_err;

  phv_assembler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .pkt_in_cnt   (pkt_in_cnt),
    .pkt_out_cnt  (pkt_out_cnt),
    .overflow_err (overflow_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [PhvLen-1:0] mq [$];
  logic [31:0]       m_in, m_out;
  logic              m_ovf;
  bit                chk_inv = 1'b0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [2047:0] make_alu(input logic [31:0] tag);
    logic [2047:0] r;
    for (int i = 0; i < 64; i++) r[i*32 +: 32] = {tag[23:0], 8'(i)};
    return r;
  endfunction

  task automatic drive(input logic [31:0] tag, input logic valid);
    bus_if.alu_out_4B      = make_alu(tag);
    bus_if.phv_remain_data = {224'h0, tag ^ 32'hA5A5_0000};
    bus_if.alu_out_valid   = valid;
  endtask

  function automatic logic [31:0] top_word(input logic [31:0] tag);
    return {tag[23:0], 8'd63};
  endfunction

  task automatic model_clear();
    mq.delete();
    m_in  = '0;
    m_out = '0;
    m_ovf = 1'b0;
  endtask

  // Reset asserted and released between clock edges.
  task automatic do_reset();
    bus_if.alu_out_valid = 1'b0;
    bus_if.ready_in      = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_clear();
  endtask

  // One clock: predict push/pop from current inputs, advance, then compare everything.
  task automatic tick();
    logic [PhvLen-1:0] exp_in, head;
    bit push, pop;
    exp_in = {bus_if.alu_out_4B, bus_if.phv_remain_data};
    push   = bus_if.alu_out_valid && (mq.size() != Depth);
    pop    = (mq.size() != 0) && bus_if.ready_in;
    if (bus_if.alu_out_valid && !push) m_ovf = 1'b1;
    @(posedge clk);
    #1;
    if (pop) begin
      void'(mq.pop_front());
      m_out++;
    end
    if (push) begin
      mq.push_back(exp_in);
      m_in++;
    end
    head = (mq.size() != 0) ? mq[0] : '0;
    check("valid", bus_if.phv_out_valid, mq.size() != 0);
    check("ready_out", bus_if.ready_out, mq.size() != Depth);
    check("phv_hi", bus_if.phv_out[PhvLen-1 -: 256], head[PhvLen-1 -: 256]);
    check("phv_lo", bus_if.phv_out[255:0], head[255:0]);
    check("phv_all", bus_if.phv_out === head, 1'b1);
    check("in_cnt", pkt_in_cnt, m_in);
    check("out_cnt", pkt_out_cnt, m_out);
    check("ovf", overflow_err, m_ovf);
    if (chk_inv) check("invariant", pkt_in_cnt - pkt_out_cnt, 32'(mq.size()));
  endtask

  initial begin
    logic [31:0] tag;
    rst_n = 1'b0;
    bus_if.ready_in = 1'b0;
    drive(32'h0, 1'b0);
    model_clear();
    #2;
    // Reset state
    check("rst_valid", bus_if.phv_out_valid, 1'b0);
    check("rst_ready", bus_if.ready_out, 1'b1);
    check("rst_in_cnt", pkt_in_cnt, 32'h0);
    check("rst_out_cnt", pkt_out_cnt, 32'h0);
    check("rst_ovf", overflow_err, 1'b0);
    check("rst_phv_hi", bus_if.phv_out[PhvLen-1 -: 256], 256'h0);
    check("rst_phv_lo", bus_if.phv_out[255:0], 256'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single bundle, container i = 0x1000_0000 + i
    for (int i = 0; i < 64; i++) bus_if.alu_out_4B[i*32 +: 32] = 32'h1000_0000 + 32'(i);
    bus_if.phv_remain_data = 256'hA5;
    bus_if.alu_out_valid   = 1'b1;
    bus_if.ready_in        = 1'b1;
    tick();
    check("t1_valid", bus_if.phv_out_valid, 1'b1);
    check("t1_top", bus_if.phv_out[2303:2272], 32'h1000_003F);
    check("t1_low", bus_if.phv_out[255:0], 256'hA5);
    bus_if.alu_out_valid = 1'b0;
    tick();
    check("t1_drop", bus_if.phv_out_valid, 1'b0);
    check("t1_in", pkt_in_cnt, 32'd1);
    check("t1_out", pkt_out_cnt, 32'd1);

    // Backpressure fill: third bundle dropped
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive(32'(k), 1'b1);
      tick();
    end
    check("bp_ready", bus_if.ready_out, 1'b0);
    check("bp_ovf", overflow_err, 1'b1);
    check("bp_in", pkt_in_cnt, 32'd2);
    check("bp_head1", bus_if.phv_out[2303:2272], top_word(32'd1));
    bus_if.alu_out_valid = 1'b0;
    bus_if.ready_in      = 1'b1;
    tick();
    check("bp_head2", bus_if.phv_out[2303:2272], top_word(32'd2));
    check("bp_ready_back", bus_if.ready_out, 1'b1);
    tick();
    check("bp_empty", bus_if.phv_out_valid, 1'b0);
    check("bp_out", pkt_out_cnt, 32'd2);
    check("bp_ovf_sticky", overflow_err, 1'b1);

    // Streaming 100 bundles with ready_in held high
    do_reset();
    bus_if.ready_in = 1'b1;
    for (int k = 0; k < 100; k++) begin
      drive(32'(100 + k), 1'b1);
      tick();
      check("stream_occ", (pkt_in_cnt - pkt_out_cnt) <= 32'd1, 1'b1);
    end
    bus_if.alu_out_valid = 1'b0;
    tick();
    check("stream_out", pkt_out_cnt, 32'd100);
    check("stream_ovf", overflow_err, 1'b0);

    // Random ready_in and gated valid
    do_reset();
    chk_inv = 1'b1;
    tag = 32'd1000;
    for (int k = 0; k < 10000; k++) begin
      bus_if.ready_in = 1'($urandom_range(0, 1));
      drive(tag, 1'($urandom_range(0, 1)) && bus_if.ready_out);
      tag++;
      tick();
    end
    chk_inv = 1'b0;
    bus_if.alu_out_valid = 1'b0;
    bus_if.ready_in      = 1'b1;
    repeat (3) tick();
    check("rand_ovf", overflow_err, 1'b0);

    // Reset mid-operation with the FIFO full
    do_reset();
    drive(32'd7, 1'b1);
    tick();
    drive(32'd8, 1'b1);
    tick();
    check("full_ready", bus_if.ready_out, 1'b0);
    bus_if.alu_out_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_valid", bus_if.phv_out_valid, 1'b0);
    check("mid_ready", bus_if.ready_out, 1'b1);
    check("mid_phv_hi", bus_if.phv_out[PhvLen-1 -: 256], 256'h0);
    check("mid_in", pkt_in_cnt, 32'h0);
    model_clear();
    #1;
    rst_n = 1'b1;
    drive(32'd9, 1'b1);
    bus_if.ready_in = 1'b1;
    tick();
    check("mid_fresh", bus_if.phv_out[2303:2272], top_word(32'd9));
    bus_if.alu_out_valid = 1'b0;
    tick();
    check("mid_after", bus_if.phv_out_valid, 1'b0);

    // Counter wrap
    do_reset();
    force dut.pkt_in_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_in_cnt_q;
    m_in = 32'hFFFF_FFFF;
    check("wrap_pre", pkt_in_cnt, 32'hFFFF_FFFF);
    drive(32'd55, 1'b1);
    bus_if.ready_in = 1'b1;
    tick();
    check("wrap_in", pkt_in_cnt, 32'h0);
    check("wrap_data", bus_if.phv_out[2303:2272], top_word(32'd55));
    bus_if.alu_out_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/phv_assembler.md
Name: phv_assembler

Overview:
- Return path of a stage's action datapath: collects the 64 per-container 32-bit ALU results plus the untouched 256-bit metadata tail, and rebuilds the full PHV for the next stage.
- Decouples ALU output timing from downstream backpressure with a small show-ahead FIFO.
- Provides valid/ready handshakes on both sides, packet counters, and a sticky overflow flag.

Parameters:
- STAGE_ID, 0, stage index; informational only, no functional effect.
- PHV_LEN, 4*8*64+256 (2304), full PHV width.
- width_4B, 32, container width.
- NUM_CONT, 64, number of 4B containers; PHV_LEN must equal NUM_CONT*width_4B+256.
- FIFO_DEPTH, 2, number of PHV entries buffered; power of two, 2..8.
- CNT_W, 32, width of the packet counters.

Ports:
- clk  in  1  stage clock.
- rst_n  in  1  asynchronous, active-low reset.
- alu_out_valid  in  1  ALU result bundle valid.
- alu_out_4B  in  width_4B*NUM_CONT  ALU results; container i occupies bits [(i+1)*32-1 -: 32].
- phv_remain_data  in  256  metadata tail; sampled together with alu_out_4B.
- ready_out  out  1  block can accept a bundle this cycle.
- phv_out  out  PHV_LEN  reassembled PHV.
- phv_out_valid  out  1  phv_out holds a valid PHV.
- ready_in  in  1  downstream accepts phv_out this cycle.
- pkt_in_cnt  out  CNT_W  bundles accepted.
- pkt_out_cnt  out  CNT_W  PHVs delivered.
- overflow_err  out  1  sticky: a bundle arrived while ready_out was low.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO count, read pointer and write pointer are cleared to 0.
  - Outputs: phv_out_valid=0, ready_out=1, pkt_in_cnt=0, pkt_out_cnt=0, overflow_err=0.
  - phv_out=0; entry storage is not reset.
  - Reset mid-operation discards every buffered PHV, with no output glitch after release.
- Packing:
  - Container i of alu_out_4B goes to phv_out[PHV_LEN-1-width_4B*(NUM_CONT-1-i) -: width_4B].
  - Equivalently phv_out[PHV_LEN-1:256] = alu_out_4B and phv_out[255:0] = phv_remain_data.
  - No reordering and no arithmetic.
- Push:
  - Occurs when alu_out_valid && ready_out at posedge clk.
  - The packed PHV is written at wr_ptr; wr_ptr increments mod FIFO_DEPTH; pkt_in_cnt increments.
- Pop:
  - Occurs when phv_out_valid && ready_in at posedge.
  - rd_ptr increments mod FIFO_DEPTH; pkt_out_cnt increments.
- Output timing:
  - phv_out_valid = (count != 0).
  - phv_out = entry[rd_ptr] (show-ahead), driven from registers.
  - Latency is exactly 1 cycle: a bundle pushed at edge N is visible on phv_out/phv_out_valid after edge N when the FIFO was empty.
  - No combinational path from alu_out_4B to phv_out.
- ready_out:
  - ready_out = (count != FIFO_DEPTH), derived only from registered count.
  - There is no combinational dependence on ready_in: when full, a same-cycle pop does not enable a push.
- Simultaneous push and pop:
  - When 0<count<FIFO_DEPTH, count is unchanged and both pointers advance.
  - When count==0 only a push is possible.
- Overflow:
  - alu_out_valid=1 while ready_out=0 drops the bundle.
  - overflow_err is set and stays 1 until reset; counters are not incremented.
- Counters wrap from 2^CNT_W-1 to 0 with no flag.
- States are implied by count:
  - EMPTY: count=0.
  - PARTIAL: 0<count<DEPTH.
  - FULL: count=DEPTH.
- Transitions:
  - EMPTY->PARTIAL on push.
  - PARTIAL->FULL on push-without-pop at count=DEPTH-1.
  - FULL->PARTIAL on pop.
  - PARTIAL->EMPTY on pop-without-push at count=1.
- Invariant: pkt_in_cnt - pkt_out_cnt == count (mod 2^CNT_W).

Test Plan:
- Reset then a single bundle:
  - Stimulus: alu_out_4B container i = 32'h1000_0000+i, phv_remain_data=256'hA5, ready_in=1.
  - Response: one cycle later phv_out_valid=1, phv_out[2303:2272]=32'h1000_003F, phv_out[255:0]=256'hA5. Valid drops the cycle after; pkt_in_cnt=pkt_out_cnt=1.
- Backpressure fill:
  - Stimulus: ready_in=0, push bundles tagged 1, 2, 3 on consecutive cycles.
  - Response: after 2 pushes ready_out=0 and bundle 3 is dropped; overflow_err=1, pkt_in_cnt=2. Releasing ready_in delivers 1 then 2 in order, and ready_out returns to 1.
- Streaming:
  - Stimulus: continuous valid with ready_in=1 for 100 cycles, data tagged by sequence.
  - Response: 100 in-order outputs, count never exceeds 1, overflow_err=0.
- Random ready_in (50%) with random valid gated by ready_out over 10k cycles:
  - Outputs match the input sequence exactly.
  - The invariant pkt_in_cnt - pkt_out_cnt == count holds every cycle.
- Reset mid-operation with FIFO full:
  - Stimulus: assert rst_n=0 asynchronously between edges.
  - Response: phv_out_valid=0, ready_out=1 immediately; after release the next push appears with no stale data.
- Counter wrap:
  - Stimulus: force pkt_in_cnt to 32'hFFFF_FFFF, then push one bundle.
  - Response: pkt_in_cnt=0, and the data path is unaffected.
